// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and a
// multi-cycle multiply/divide freeze, with a saturating stall counter.
module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       IF_ID_Rs_i,
  input  logic [4:0]       IF_ID_Rt_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_Rt_i,
  input  logic             mdu_start_i,
  input  logic             branch_taken_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             IF_flush_o,
  output logic             ctrl_bubble_o,
  output logic             ID_EX_hold_o,
  output logic             mdu_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {RUN = 1'b0, MDU = 1'b1} state_t;

  localparam logic [3:0] MDU_LOAD = 4'(MDU_LAT - 2);

  state_t           state_q, state_d;
  logic [3:0]       mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mdu_busy_q;
  logic             lu_hazard;
  logic             run_decode;

  // Register 0 is hardwired zero, so a load into it can never create a hazard.
  assign lu_hazard = ID_EX_MemRead_i && (ID_EX_Rt_i != 5'd0) &&
                     ((ID_EX_Rt_i == IF_ID_Rs_i) || (ID_EX_Rt_i == IF_ID_Rt_i));

  // A reset cycle decodes as RUN even if the registered state is still MDU.
  assign run_decode = !rst_n_i || (state_q == RUN);

  always_comb begin
    PC_write_o    = 1'b1;
    IF_ID_write_o = 1'b1;
    IF_flush_o    = 1'b0;
    ctrl_bubble_o = 1'b0;
    ID_EX_hold_o  = 1'b0;
    state_d       = state_q;
    mdu_cnt_d     = mdu_cnt_q;
    if (run_decode) begin
      if (mdu_start_i) begin
        PC_write_o    = 1'b0;
        IF_ID_write_o = 1'b0;
        ID_EX_hold_o  = 1'b1;
        // With the minimum latency the start cycle alone is the whole freeze.
        if (MDU_LOAD != 4'd0) begin
          state_d   = MDU;
          mdu_cnt_d = MDU_LOAD;
        end
      end else if (lu_hazard) begin
        PC_write_o    = 1'b0;
        IF_ID_write_o = 1'b0;
        ctrl_bubble_o = 1'b1;
      end else begin
        IF_flush_o = branch_taken_i;
      end
    end else begin
      PC_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
      ID_EX_hold_o  = 1'b1;
      mdu_cnt_d     = mdu_cnt_q - 4'd1;
      if (mdu_cnt_d == 4'd0) begin
        state_d = RUN;
      end
    end
  end

  assign stall_cnt_d = (!PC_write_o && (stall_cnt_q != {CNT_W{1'b1}}))
                     ? stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}
                     : stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= RUN;
      mdu_cnt_q   <= 4'd0;
      stall_cnt_q <= '0;
      mdu_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mdu_busy_q  <= (state_d == MDU);
    end
  end

  assign mdu_busy_o  = mdu_busy_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
- REQ-001 Parameter MDU_LAT, default 4: EX-stage cycles a multiply/divide occupies; legal range 2..15.
- REQ-002 Parameter CNT_W, default 16: width of the stall statistics counter.
- REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
- REQ-004 rst_n_i  in  1  reset, synchronous, active-low.
- REQ-005 IF_ID_Rs_i  in  5  Rs address of the instruction in ID.
- REQ-006 IF_ID_Rt_i  in  5  Rt address of the instruction in ID.
- REQ-007 ID_EX_MemRead_i  in  1  MEM-bundle read bit of the instruction in EX.
- REQ-008 ID_EX_Rt_i  in  5  Rt (load destination) of the instruction in EX.
- REQ-009 mdu_start_i  in  1  EX holds a multi-cycle multiply/divide this cycle.
- REQ-010 branch_taken_i  in  1  branch/jump resolved taken in ID this cycle.
- REQ-011 PC_write_o  out  1  PC update enable.
- REQ-012 IF_ID_write_o  out  1  IF/ID register load enable.
- REQ-013 IF_flush_o  out  1  zero the IF/ID instruction on the next edge.
- REQ-014 ctrl_bubble_o  out  1  force WB/MEM/EX bundles into ID/EX to zero.
- REQ-015 ID_EX_hold_o  out  1  ID/EX register keeps its contents.
- REQ-016 mdu_busy_o  out  1  high while state is MDU.
- REQ-017 stall_cnt_o  out  CNT_W  saturating count of stall cycles.

Function
- REQ-018 Two states shall exist: RUN and MDU; a down-counter mdu_cnt (4 bits) shall track MDU residency.
- REQ-019 Load-use hazard (LU) shall be defined as: ID_EX_MemRead_i=1, ID_EX_Rt_i!=0, and ID_EX_Rt_i equal to IF_ID_Rs_i or IF_ID_Rt_i.
- REQ-020 In RUN, with mdu_start_i=0 and LU=0: PC_write_o=1, IF_ID_write_o=1, ctrl_bubble_o=0, ID_EX_hold_o=0, IF_flush_o=branch_taken_i.
- REQ-021 In RUN with LU=1 and mdu_start_i=0: PC_write_o=0, IF_ID_write_o=0, ctrl_bubble_o=1, IF_flush_o=0 (branch ignored; it re-resolves next cycle); exactly one bubble per LU-true cycle.
- REQ-022 In RUN with mdu_start_i=1: transition to MDU, load mdu_cnt=MDU_LAT-2; in that same cycle PC_write_o=0, IF_ID_write_o=0, ID_EX_hold_o=1, ctrl_bubble_o=0, IF_flush_o=0; mdu_start_i has priority over LU and branch_taken_i.
- REQ-023 In MDU: PC_write_o=0, IF_ID_write_o=0, ID_EX_hold_o=1, ctrl_bubble_o=0, IF_flush_o=0, mdu_busy_o=1; LU, branch_taken_i and mdu_start_i ignored.
- REQ-024 In MDU, mdu_cnt shall decrement each cycle; when mdu_cnt=0 the next state is RUN.
- REQ-025 Total freeze for one multiply/divide shall be exactly MDU_LAT-1 cycles (start cycle plus MDU cycles); the first RUN cycle after MDU evaluates all inputs normally.
- REQ-026 Outputs other than mdu_busy_o and stall_cnt_o are combinational from state and inputs; mdu_busy_o and stall_cnt_o are direct register outputs.
- REQ-027 stall_cnt_o shall increment by 1 on every edge following a cycle in which PC_write_o=0, saturating at 2^CNT_W-1 without wrap.
- REQ-028 Register 0 shall never raise LU, regardless of the IF_ID addresses.

Reset
- REQ-029 While rst_n_i=0 at an edge: state<=RUN, mdu_cnt<=0, stall_cnt_o<=0.
- REQ-030 During a reset cycle, outputs follow RUN decoding of current inputs; reset asserted in the middle of MDU aborts it, and the cycle after reset release is RUN.

Verification
- REQ-031 ID_EX_MemRead_i=1, ID_EX_Rt_i=8, IF_ID_Rs_i=8 for one cycle -> PC_write_o=0, IF_ID_write_o=0, ctrl_bubble_o=1 that cycle; stall_cnt_o=1 next cycle.
- REQ-032 Same as REQ-031 but ID_EX_Rt_i=0 and IF_ID_Rs_i=0 -> no stall, PC_write_o=1, stall_cnt_o unchanged.
- REQ-033 MDU_LAT=4, mdu_start_i pulse in cycle T -> PC_write_o=0 and ID_EX_hold_o=1 in T..T+2, mdu_busy_o=1 in T+1..T+2, RUN in T+3, stall_cnt_o +3.
- REQ-034 branch_taken_i=1 with LU=1 -> IF_flush_o=0, ctrl_bubble_o=1; next cycle, LU cleared and branch_taken_i=1 -> IF_flush_o=1, PC_write_o=1.
- REQ-035 CNT_W=4, hold LU true 20 cycles -> stall_cnt_o stops at 15.
- REQ-036 rst_n_i=0 in the second cycle of MDU -> mdu_busy_o=0 and stall_cnt_o=0 after that edge; RUN behaviour immediately after release.
